// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the port not granted last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  req_i,
  input  logic  req_d,
  output logic  any_c,
  output port_t gnt_c
);

  port_t last_gnt;

  always_comb begin
    any_c = req_i | req_d;
    gnt_c = PORT_I;
    if (req_i && req_d) begin
      gnt_c = (last_gnt == PORT_I) ? PORT_D : PORT_I;
    end else if (req_d) begin
      gnt_c = PORT_D;
    end
  end

  // Reset to D so the first tie after reset goes to the fetch port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= PORT_D;
    end else if (en && any_c) begin
      last_gnt <= gnt_c;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port mem between a fetch port and a load/store port,
// filtering misaligned and out-of-range accesses before they reach mem.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] CAPACITY = ADDR_W'(16'hffff)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_memIn,
  output logic              m_read,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_memOut
);

  state_t state, state_nxt;

  // The latched address and store data live in m_address/m_memIn, which
  // are only non-zero during ACCESS, the one cycle they are needed.
  port_t lat_port, lat_port_nxt;
  logic  lat_we, lat_we_nxt;

  logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;
  logic              i_done_nxt, d_done_nxt, i_err_nxt, d_err_nxt;
  logic [ADDR_W-1:0] m_address_nxt;
  logic [DATA_W-1:0] m_mem_in_nxt;
  logic              m_read_nxt, m_write_nxt;

  logic              arb_en_c, any_c;
  port_t             gnt_c;
  logic              win_we_c, win_bad_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_wdata_c;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en_c),
    .req_i (i_req),
    .req_d (d_req),
    .any_c (any_c),
    .gnt_c (gnt_c)
  );

  // Winner's request fields and legality check.
  always_comb begin
    win_we_c    = 1'b0;
    win_addr_c  = i_addr;
    win_wdata_c = '0;
    if (gnt_c == PORT_D) begin
      win_we_c    = d_we;
      win_addr_c  = d_addr;
      win_wdata_c = d_wdata;
    end
    win_bad_c = ((win_addr_c[1:0] & ALIGN_MASK) != 2'b00) || (win_addr_c > CAPACITY);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    lat_port_nxt  = lat_port;
    lat_we_nxt    = lat_we;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;
    i_err_nxt     = i_err;
    d_err_nxt     = d_err;
    i_done_nxt    = 1'b0;
    d_done_nxt    = 1'b0;
    m_address_nxt = '0;
    m_mem_in_nxt  = '0;
    m_read_nxt    = 1'b0;
    m_write_nxt   = 1'b0;
    arb_en_c      = 1'b0;

    case (state)
      IDLE: begin
        arb_en_c = 1'b1;
        if (any_c) begin
          lat_port_nxt = gnt_c;
          lat_we_nxt   = win_we_c;
          if (win_bad_c) begin
            state_nxt = RESP;
            if (gnt_c == PORT_D) begin
              d_done_nxt  = 1'b1;
              d_err_nxt   = 1'b1;
              d_rdata_nxt = '0;
            end else begin
              i_done_nxt  = 1'b1;
              i_err_nxt   = 1'b1;
              i_rdata_nxt = '0;
            end
          end else begin
            state_nxt     = ACCESS;
            m_address_nxt = win_addr_c;
            m_read_nxt    = ~win_we_c;
            m_write_nxt   = win_we_c;
            m_mem_in_nxt  = win_we_c ? win_wdata_c : '0;
          end
        end
      end
      ACCESS: begin
        state_nxt = RESP;
        if (lat_port == PORT_D) begin
          d_done_nxt  = 1'b1;
          d_err_nxt   = 1'b0;
          d_rdata_nxt = lat_we ? '0 : m_memOut;
        end else begin
          i_done_nxt  = 1'b1;
          i_err_nxt   = 1'b0;
          i_rdata_nxt = m_memOut;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_port  <= PORT_I;
      lat_we    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_err     <= 1'b0;
      d_err     <= 1'b0;
      m_address <= '0;
      m_memIn   <= '0;
      m_read    <= 1'b0;
      m_write   <= 1'b0;
    end else begin
      state     <= state_nxt;
      lat_port  <= lat_port_nxt;
      lat_we    <= lat_we_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      i_done    <= i_done_nxt;
      d_done    <= d_done_nxt;
      i_err     <= i_err_nxt;
      d_err     <= d_err_nxt;
      m_address <= m_address_nxt;
      m_memIn   <= m_mem_in_nxt;
      m_read    <= m_read_nxt;
      m_write   <= m_write_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural mem model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_done, i_err, d_done, d_err;
  logic [31:0] m_address, m_memIn, m_memOut;
  logic        m_read, m_write;

  logic [31:0] mem_model [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .d_err     (d_err),
    .m_address (m_address),
    .m_memIn   (m_memIn),
    .m_read    (m_read),
    .m_write   (m_write),
    .m_memOut  (m_memOut)
  );

  always #5 clk = ~clk;

  // Behavioural single-port mem: combinational read, write on posedge.
  assign m_memOut = mem_model[m_address[15:0]];
  always @(posedge clk) begin
    if (m_write) mem_model[m_address[15:0]] <= m_memIn;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Drive one D-port request; lat = done cycle counted from the sample edge, -1 on timeout.
  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int rd_cyc, output int wr_cyc, output logic other);
    lat = -1; rdata = 'x; err = 1'bx; rd_cyc = 0; wr_cyc = 0; other = 1'b0;
    @(negedge clk);
    d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m_read)  rd_cyc++;
      if (m_write) wr_cyc++;
      if (i_done)  other = 1'b1;
      if (d_done) begin
        lat = k; rdata = d_rdata; err = d_err;
        break;
      end
    end
    d_req = 1'b0;
    @(negedge clk);
    if (m_read)  rd_cyc++;
    if (m_write) wr_cyc++;
  endtask

  task automatic i_access(input logic [31:0] addr,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int rd_cyc, output int wr_cyc, output logic other);
    lat = -1; rdata = 'x; err = 1'bx; rd_cyc = 0; wr_cyc = 0; other = 1'b0;
    @(negedge clk);
    i_addr = addr; i_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m_read)  rd_cyc++;
      if (m_write) wr_cyc++;
      if (d_done)  other = 1'b1;
      if (i_done) begin
        lat = k; rdata = i_rdata; err = i_err;
        break;
      end
    end
    i_req = 1'b0;
    @(negedge clk);
    if (m_read)  rd_cyc++;
    if (m_write) wr_cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({i_done, i_err, d_done, d_err, m_read, m_write} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000", {i_done, i_err, d_done, d_err, m_read, m_write});
    end
    n_checks++;
    if ({i_rdata, d_rdata, m_address, m_memIn} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_buses: got %h %h %h %h expected all 0", i_rdata, d_rdata, m_address, m_memIn);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int lat, rd, wr; logic [31:0] rdata; logic err, other;
    d_access(1'b1, 32'h40, 32'hDEADBEEF, lat, rdata, err, rd, wr, other);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL store_latency: got %0d expected 2", lat); end
    n_checks++;
    if (wr !== 1 || rd !== 0) begin n_fail++; $display("FAIL store_strobes: write cycles %0d read cycles %0d expected 1 0", wr, rd); end
    n_checks++;
    if (err !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL store_resp: err %b rdata %h expected 0 0", err, rdata); end
    n_checks++;
    if (mem_model[16'h40] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_commit: mem[40] %h expected deadbeef", mem_model[16'h40]); end
    d_access(1'b0, 32'h40, 32'h0, lat, rdata, err, rd, wr, other);
    n_checks++;
    if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin n_fail++; $display("FAIL load_data: rdata %h err %b expected deadbeef 0", rdata, err); end
    n_checks++;
    if (lat !== 2 || rd !== 1 || wr !== 0) begin n_fail++; $display("FAIL load_timing: lat %0d rd %0d wr %0d expected 2 1 0", lat, rd, wr); end
  endtask

  task automatic test_fetch();
    int lat, rd, wr; logic [31:0] rdata; logic err, other;
    i_access(32'h28, lat, rdata, err, rd, wr, other);
    n_checks++;
    if (rdata !== 32'h00B50533 || err !== 1'b0) begin n_fail++; $display("FAIL fetch_data: rdata %h err %b expected 00b50533 0", rdata, err); end
    n_checks++;
    if (lat !== 2 || rd !== 1 || wr !== 0) begin n_fail++; $display("FAIL fetch_timing: lat %0d rd %0d wr %0d expected 2 1 0", lat, rd, wr); end
    n_checks++;
    if (other !== 1'b0) begin n_fail++; $display("FAIL fetch_other_port: d_done seen %b expected 0", other); end
  endtask

  task automatic test_misaligned();
    int lat, rd, wr; logic [31:0] rdata; logic err, other;
    d_access(1'b1, 32'h42, 32'h11111111, lat, rdata, err, rd, wr, other);
    n_checks++;
    if (lat !== 1 || err !== 1'b1) begin n_fail++; $display("FAIL misalign_resp: lat %0d err %b expected 1 1", lat, err); end
    n_checks++;
    if (wr !== 0 || rd !== 0 || rdata !== 32'h0) begin n_fail++; $display("FAIL misalign_nomem: wr %0d rd %0d rdata %h expected 0 0 0", wr, rd, rdata); end
    d_access(1'b0, 32'h40, 32'h0, lat, rdata, err, rd, wr, other);
    n_checks++;
    if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin n_fail++; $display("FAIL misalign_reload: rdata %h err %b expected deadbeef 0", rdata, err); end
  endtask

  task automatic test_out_of_range();
    int lat, rd, wr; logic [31:0] rdata; logic err, other;
    i_access(32'h10000, lat, rdata, err, rd, wr, other);
    n_checks++;
    if (lat !== 1 || err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL oor_resp: lat %0d err %b rdata %h expected 1 1 0", lat, err, rdata); end
    n_checks++;
    if (rd !== 0 || wr !== 0) begin n_fail++; $display("FAIL oor_nomem: rd %0d wr %0d expected 0 0", rd, wr); end
    i_access(32'h0000FFFC, lat, rdata, err, rd, wr, other);
    n_checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== 1) begin n_fail++; $display("FAIL top_word: lat %0d err %b rd %0d expected 2 0 1", lat, err, rd); end
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    int   last_c, n_done;
    pulse_reset();
    i_addr = 32'h28; d_addr = 32'h40; d_we = 1'b0; d_wdata = 32'h0;
    i_req = 1'b1; d_req = 1'b1;
    exp_d = 1'b0; last_c = -1; n_done = 0;
    for (int c = 0; c < 40 && n_done < 6; c++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        n_checks++;
        if (d_done !== exp_d || (i_done && d_done)) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: i_done %b d_done %b expected d_done %b only", n_done, i_done, d_done, exp_d);
        end
        if (last_c >= 0) begin
          n_checks++;
          if (c - last_c !== 3) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", n_done, c - last_c); end
        end
        n_checks++;
        if (d_done ? (d_rdata !== 32'hDEADBEEF) : (i_rdata !== 32'h00B50533)) begin
          n_fail++;
          $display("FAIL rr_data[%0d]: i_rdata %h d_rdata %h", n_done, i_rdata, d_rdata);
        end
        exp_d  = ~exp_d;
        last_c = c;
        n_done++;
      end
      i_req = ~i_done;
      d_req = ~d_done;
    end
    i_req = 1'b0; d_req = 1'b0;
    n_checks++;
    if (n_done !== 6) begin n_fail++; $display("FAIL rr_count: got %0d completions expected 6", n_done); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int lat, rd, wr; logic [31:0] rdata; logic err, other;
    @(negedge clk);
    d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h12345678; d_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_write !== 1'b1 || m_address !== 32'h44) begin n_fail++; $display("FAIL midrst_access: m_write %b m_address %h expected 1 44", m_write, m_address); end
    reset = 1'b1;
    d_req = 1'b0;
    #1;
    n_checks++;
    if ({m_write, m_read, d_done, i_done, d_err, i_err} !== 6'b0 || {m_address, m_memIn, d_rdata, i_rdata} !== 128'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: m_write %b m_address %h m_memIn %h d_rdata %h i_rdata %h expected all 0",
               m_write, m_address, m_memIn, d_rdata, i_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (dut.state !== mem_arb_pkg::IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d expected 0", dut.state); end
    n_checks++;
    if (mem_model[16'h44] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL midrst_nocommit: mem[44] %h expected cafef00d", mem_model[16'h44]); end
    @(negedge clk);
    d_access(1'b1, 32'h44, 32'h12345678, lat, rdata, err, rd, wr, other);
    n_checks++;
    if (lat !== 2 || err !== 1'b0 || wr !== 1) begin n_fail++; $display("FAIL midrst_reissue: lat %0d err %b wr %0d expected 2 0 1", lat, err, wr); end
    n_checks++;
    if (mem_model[16'h44] !== 32'h12345678) begin n_fail++; $display("FAIL midrst_commit: mem[44] %h expected 12345678", mem_model[16'h44]); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem_model[a] = 32'h0;
    mem_model[16'h28]   = 32'h00B50533;
    mem_model[16'h44]   = 32'hCAFEF00D;
    mem_model[16'hFFFC] = 32'hA5A5_5A5A;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    test_reset();
    test_store_load();
    test_fetch();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_access();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port behavioural `mem` unit between an instruction-fetch requester (I-port) and a load/store requester (D-port).
- Drives the `mem` pins: address, memIn, read and write; `mem` itself is not modified.
- Serialises the two requesters with round-robin arbitration and a req/done handshake.
- Filters misaligned and out-of-range accesses before they reach `mem`, so `mem` never sees an illegal read or write.

Parameters:
- ADDR_W, 32, width of all address buses.
- DATA_W, 32, width of all data buses.
- CAPACITY, 16'hffff, highest legal word address; must match the `mem` instance.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  1  fetch request; held high until i_done.
- i_addr  input  ADDR_W  fetch address; stable while i_req is high.
- i_rdata  output  DATA_W  fetched word; valid while i_done is high.
- i_done  output  1  one-cycle completion pulse for the I-port.
- i_err  output  1  error flag, qualified by i_done.
- d_req  input  1  data request; held high until d_done.
- d_we  input  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_rdata  output  DATA_W  load result; valid while d_done is high.
- d_done  output  1  one-cycle completion pulse for the D-port.
- d_err  output  1  error flag, qualified by d_done.
- m_address  output  ADDR_W  to mem.address.
- m_memIn  output  DATA_W  to mem.memIn.
- m_read  output  1  to mem.read.
- m_write  output  1  to mem.write.
- m_memOut  input  DATA_W  from mem.memOut (combinational read data).

Behaviour:
- The clock port is `clk` and the reset port is `reset`. Reset is asynchronous and active-high, with one clock domain.
- Reset values:
  - state = IDLE; last_gnt = D.
  - All done, err, rdata, m_* outputs = 0.
  - The latched request (port, we, addr, wdata) = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitrate among the asserted reqs.
    - Single requester: that requester wins.
    - Both requesting: the port other than last_gnt wins, then last_gnt <= winner. After reset the first tie therefore goes to I.
  - Latch the winner's port, we, addr and wdata. I-port requests always have we = 0.
  - If the latched address is misaligned (addr[1:0] != 0) or addr > CAPACITY: go to RESP with err = 1 and rdata = 0. No mem access occurs.
  - Otherwise go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (exactly one cycle):
  - m_address = latched addr.
  - Load: m_read = 1. Store: m_write = 1 and m_memIn = latched wdata.
  - On the closing posedge:
    - A load captures m_memOut into the port's rdata register.
    - A store commits in mem on the same edge; rdata is cleared to 0.
  - Next state: RESP.
- Outside ACCESS, m_read = m_write = 0 and m_address = m_memIn = 0.
- RESP (one cycle):
  - The winner's done = 1, with its err and rdata registered.
  - The other port's done = 0.
  - No arbitration happens in RESP; this guarantees the requester has dropped req before the next IDLE.
  - Next state: IDLE.
- Latency and throughput:
  - A legal access is sampled at edge E0 in IDLE, occupies ACCESS in (E0, E1], and shows done in (E1, E2].
  - An error access skips ACCESS, so done appears in (E0, E1].
  - Peak throughput is 1 legal access per 3 cycles.
- Handshake:
  - The requester holds req and its fields stable until it sees done, then drops req in the done cycle.
  - A req that is still high in the next IDLE is treated as a new request.
  - rdata holds its value until the next completion on that port.
- The losing requester waits without penalty; its req stays pending and it wins the next arbitration.
- Reset asserted mid-ACCESS: outputs clear immediately. m_write falls before the next posedge, so no store commits. In-flight requests are dropped and requesters must reissue.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - port ids (PORT_I = 1'b0, PORT_D = 1'b1);
  - ALIGN_MASK = 2'b11.
- One sub-module, rr_arb2: 2-way round-robin grant logic with a last_gnt register and an enable input.

Test Plan:
- Store with d_req = 1, d_we = 1, d_addr = 32'h40, d_wdata = 32'hDEADBEEF.
  - m_write = 1 for exactly one cycle and d_done pulses 2 cycles after the sample edge.
  - A subsequent load from 32'h40 returns d_rdata = 32'hDEADBEEF with d_err = 0.
- Fetch with i_req = 1, i_addr = 32'h28, where 32'h28 is preloaded with an R-type word such as 32'h00B50533 (opcode field 7'h33).
  - i_done pulses with i_rdata = 32'h00B50533.
  - m_read is high only during ACCESS.
- Both requesters continuously requesting, right after reset.
  - Grants alternate I, D, I, D, with one done every 3 cycles.
  - No port is starved.
- Misaligned d_addr = 32'h42 store.
  - d_done pulses 1 cycle after the sample edge with d_err = 1.
  - m_write stays 0 throughout; a reload from 32'h40 shows the memory word unchanged.
- Out-of-range i_addr = 32'h10000 (> CAPACITY).
  - i_done pulses with i_err = 1 and i_rdata = 0.
  - mem is never read.
- Reset pulsed during the ACCESS cycle of a store to 32'h44 with data 32'h12345678.
  - All outputs go to 0 immediately and the state returns to IDLE.
  - 32'h44 still holds its old contents.
  - A reissued request then completes normally.
